// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared RAM port types and arbiter state encodings.
package ram_arbiter_pkg;
  typedef logic [31:0] ram_addr_t;
  typedef logic [31:0] ram_data_t;
  typedef enum logic {CHIP_DISABLE = 1'b0, CHIP_ENABLE = 1'b1} chip_status_t;
  typedef enum logic {RST_ENABLE = 1'b0, RST_DISABLE = 1'b1} reset_status_t;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic [1:0] {GRANT_NONE, GRANT_IF, GRANT_DM} arb_grant_t;
  localparam logic [3:0] SEL_ALL = 4'b1111;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between instruction fetch and MEM-stage data,
// with fixed wait states, registered responses and bounded data bursts.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int WAIT_STATES    = 1,
  parameter int DATA_BURST_MAX = 2
) (
  input  logic          clk,
  input  reset_status_t rst,
  input  logic          if_req_i,
  input  ram_addr_t     if_addr_i,
  output ram_data_t     if_data_o,
  output logic          if_ack_o,
  input  chip_status_t  dm_ce_i,
  input  logic          dm_we_i,
  input  logic [3:0]    dm_sel_i,
  input  ram_addr_t     dm_addr_i,
  input  ram_data_t     dm_data_i,
  output ram_data_t     dm_data_o,
  output logic          dm_ack_o,
  output chip_status_t  ram_ce_o,
  output logic          ram_we_o,
  output logic [3:0]    ram_sel_o,
  output ram_addr_t     ram_addr_o,
  output ram_data_t     ram_data_o,
  input  ram_data_t     ram_data_i,
  output logic          stall_req_o
);
  localparam int BW = 4;
  arb_state_t   state_q, state_d;
  arb_grant_t   grant_q, grant_d;
  logic [2:0]   wait_q, wait_d;
  logic [BW-1:0] burst_q, burst_d;
  chip_status_t ce_q, ce_d;
  logic         we_q, we_d;
  logic [3:0]   sel_q, sel_d;
  ram_addr_t    addr_q, addr_d;
  ram_data_t    wdata_q, wdata_d;
  ram_data_t    if_data_q, if_data_d, dm_data_q, dm_data_d;
  logic         if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic         dm_pend, burst_full;
  assign dm_pend    = dm_ce_i == CHIP_ENABLE;
  assign burst_full = burst_q >= BW'(DATA_BURST_MAX);
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    wait_d    = wait_q;
    burst_d   = burst_q;
    ce_d      = ce_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    dm_data_d = dm_data_q;
    if_ack_d  = 1'b0;
    dm_ack_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        burst_d = if_req_i ? burst_q : '0;
        // data wins ties until it has used up its burst allowance
        if (dm_pend && !(if_req_i && burst_full)) begin
          state_d = ARB_ACCESS;
          grant_d = GRANT_DM;
          ce_d    = CHIP_ENABLE;
          we_d    = dm_we_i;
          sel_d   = dm_sel_i;
          addr_d  = dm_addr_i;
          wdata_d = dm_data_i;
          wait_d  = 3'(WAIT_STATES);
          burst_d = if_req_i ? burst_q + 1'b1 : '0;
        end else if (if_req_i) begin
          state_d = ARB_ACCESS;
          grant_d = GRANT_IF;
          ce_d    = CHIP_ENABLE;
          we_d    = 1'b0;
          sel_d   = SEL_ALL;
          addr_d  = if_addr_i;
          wdata_d = '0;
          wait_d  = 3'(WAIT_STATES);
          burst_d = '0;
        end
      end
      ARB_ACCESS: begin
        wait_d = wait_q - 3'd1;
        if (wait_q == '0) begin
          state_d   = ARB_RESP;
          grant_d   = GRANT_NONE;
          wait_d    = '0;
          ce_d      = CHIP_DISABLE;
          we_d      = 1'b0;
          sel_d     = '0;
          addr_d    = '0;
          wdata_d   = '0;
          if_ack_d  = grant_q == GRANT_IF;
          dm_ack_d  = grant_q == GRANT_DM;
          if_data_d = grant_q == GRANT_IF ? ram_data_i : if_data_q;
          dm_data_d = (grant_q == GRANT_DM && !we_q) ? ram_data_i : dm_data_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= ARB_IDLE;
      grant_q   <= GRANT_NONE;
      wait_q    <= '0;
      burst_q   <= '0;
      ce_q      <= CHIP_DISABLE;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      dm_data_q <= '0;
      if_ack_q  <= 1'b0;
      dm_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wait_q    <= wait_d;
      burst_q   <= burst_d;
      ce_q      <= ce_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
      if_ack_q  <= if_ack_d;
      dm_ack_q  <= dm_ack_d;
    end
  end
  assign ram_ce_o    = ce_q;
  assign ram_we_o    = we_q;
  assign ram_sel_o   = sel_q;
  assign ram_addr_o  = addr_q;
  assign ram_data_o  = wdata_q;
  assign if_data_o   = if_data_q;
  assign dm_data_o   = dm_data_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign stall_req_o = (rst != RST_ENABLE) && ((dm_pend && !dm_ack_q) || (if_req_i && !if_ack_q));
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: per-cycle vector table for the RAM command side plus a
// read-data scoreboard, with hand sequences for reset abort and zero wait states.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  reset_status_t rst;
  logic if_req_i, dm_we_i;
  ram_addr_t if_addr_i, dm_addr_i;
  chip_status_t dm_ce_i;
  logic [3:0] dm_sel_i;
  ram_data_t dm_data_i;
  ram_data_t if_data_o, dm_data_o, ram_data_o, ram_data_i;
  ram_addr_t ram_addr_o;
  logic if_ack_o, dm_ack_o, ram_we_o, stall_req_o;
  logic [3:0] ram_sel_o;
  chip_status_t ram_ce_o;
  ram_data_t if_data_w0, dm_data_w0, ram_data_o_w0, ram_data_i_w0;
  ram_addr_t ram_addr_w0;
  logic if_ack_w0, dm_ack_w0, ram_we_w0, stall_w0;
  logic [3:0] ram_sel_w0;
  chip_status_t ram_ce_w0;
  int n_vec = 0, n_err = 0;
  ram_data_t if_q[$], dm_q[$];
  ram_data_t last_rd = '0;

  function automatic ram_data_t ram_model(input ram_addr_t a);
    return a == 32'h100 ? 32'h2402_0005 : {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign ram_data_i    = ram_model(ram_addr_o);
  assign ram_data_i_w0 = ram_model(ram_addr_w0);

  ram_arbiter #(.WAIT_STATES(1), .DATA_BURST_MAX(2)) u_dut (
    .clk(clk), .rst(rst), .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o),
    .if_ack_o(if_ack_o), .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i),
    .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i), .dm_data_o(dm_data_o), .dm_ack_o(dm_ack_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .stall_req_o(stall_req_o));

  ram_arbiter #(.WAIT_STATES(0), .DATA_BURST_MAX(2)) u_dut0 (
    .clk(clk), .rst(rst), .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_w0),
    .if_ack_o(if_ack_w0), .dm_ce_i(dm_ce_i), .dm_we_i(dm_we_i), .dm_sel_i(dm_sel_i),
    .dm_addr_i(dm_addr_i), .dm_data_i(dm_data_i), .dm_data_o(dm_data_w0), .dm_ack_o(dm_ack_w0),
    .ram_ce_o(ram_ce_w0), .ram_we_o(ram_we_w0), .ram_sel_o(ram_sel_w0), .ram_addr_o(ram_addr_w0),
    .ram_data_o(ram_data_o_w0), .ram_data_i(ram_data_i_w0), .stall_req_o(stall_w0));

  typedef struct {
    logic ifr; ram_addr_t ia; logic dce, dwe; logic [3:0] dsel; ram_addr_t da; ram_data_t dd;
    logic pi, pd;
    logic ce, we; logic [3:0] sel; ram_addr_t addr; ram_data_t wd; logic iack, dack, stall;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] ifr, ia, dce, dwe, dsel, da, dd, pi, pd,
                              ce, we, sel, addr, wd, iack, dack, stall);
    vec_t v;
    v.ifr = ifr[0]; v.ia = ia; v.dce = dce[0]; v.dwe = dwe[0]; v.dsel = dsel[3:0];
    v.da = da; v.dd = dd; v.pi = pi[0]; v.pd = pd[0];
    v.ce = ce[0]; v.we = we[0]; v.sel = sel[3:0]; v.addr = addr; v.wd = wd;
    v.iack = iack[0]; v.dack = dack[0]; v.stall = stall[0];
    return v;
  endfunction

  task automatic add(input vec_t v, input int n);
    repeat (n) vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst == RST_DISABLE && if_ack_o) begin
      if (if_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL if_sb: unexpected if_ack_o, got 1 expected 0");
      end else chk("if_data", if_data_o, if_q.pop_front());
    end
    if (rst == RST_DISABLE && dm_ack_o) begin
      if (dm_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL dm_sb: unexpected dm_ack_o, got 1 expected 0");
      end else chk("dm_data", dm_data_o, dm_q.pop_front());
    end
  end

  initial begin
    vec_t v;
    rst = RST_ENABLE; if_req_i = 1'b1; if_addr_i = '0; dm_ce_i = CHIP_ENABLE;
    dm_we_i = 1'b0; dm_sel_i = '0; dm_addr_i = '0; dm_data_i = '0;
    add(mk(1,'h100,0,0,0,0,0, 1,0, 0,0,0,0,0, 0,0,1), 1);
    add(mk(1,'h100,0,0,0,0,0, 0,0, 1,0,'hF,'h100,0, 0,0,1), 2);
    add(mk(1,'h100,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0,0), 1);
    add(mk(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0), 1);
    add(mk(1,'h104,1,0,'hF,'h2000,0, 1,1, 0,0,0,0,0, 0,0,1), 1);
    add(mk(1,'h104,1,0,'hF,'h2000,0, 0,0, 1,0,'hF,'h2000,0, 0,0,1), 2);
    add(mk(1,'h104,1,0,'hF,'h2000,0, 0,0, 0,0,0,0,0, 0,1,1), 1);
    add(mk(1,'h104,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0,1), 1);
    add(mk(1,'h104,0,0,0,0,0, 0,0, 1,0,'hF,'h104,0, 0,0,1), 2);
    add(mk(1,'h104,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0,0), 1);
    add(mk(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0), 1);
    add(mk(0,0,1,1,'hE,'h2003,'hAB, 0,1, 0,0,0,0,0, 0,0,1), 1);
    add(mk(0,0,1,1,'hE,'h2003,'hAB, 0,0, 1,1,'hE,'h2003,'hAB, 0,0,1), 2);
    add(mk(0,0,1,1,'hE,'h2003,'hAB, 0,0, 0,0,0,0,0, 0,1,0), 1);
    add(mk(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0), 1);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 1,1, 0,0,0,0,0, 0,0,1), 1);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 0,0, 1,0,'hF,'h3000,0, 0,0,1), 2);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 0,0, 0,0,0,0,0, 0,1,1), 1);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 0,1, 0,0,0,0,0, 0,0,1), 1);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 0,0, 1,0,'hF,'h3000,0, 0,0,1), 2);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 0,0, 0,0,0,0,0, 0,1,1), 1);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 0,0, 0,0,0,0,0, 0,0,1), 1);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 0,0, 1,0,'hF,'h108,0, 0,0,1), 2);
    add(mk(1,'h108,1,0,'hF,'h3000,0, 0,0, 0,0,0,0,0, 1,0,1), 1);
    add(mk(1,'h10C,1,0,'hF,'h3000,0, 1,1, 0,0,0,0,0, 0,0,1), 1);
    add(mk(1,'h10C,1,0,'hF,'h3000,0, 0,0, 1,0,'hF,'h3000,0, 0,0,1), 2);
    add(mk(1,'h10C,1,0,'hF,'h3000,0, 0,0, 0,0,0,0,0, 0,1,1), 1);
    add(mk(1,'h10C,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0,1), 1);
    add(mk(1,'h10C,0,0,0,0,0, 0,0, 1,0,'hF,'h10C,0, 0,0,1), 2);
    add(mk(1,'h10C,0,0,0,0,0, 0,0, 0,0,0,0,0, 1,0,0), 1);
    add(mk(0,0,0,0,0,0,0, 0,0, 0,0,0,0,0, 0,0,0), 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall_req_o), 0);
    chk("rst_ce", 32'(ram_ce_o == CHIP_ENABLE), 0);
    chk("rst_cmd", {27'(0), ram_we_o, ram_sel_o}, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_wdata", ram_data_o, 0);
    chk("rst_acks", {30'(0), if_ack_o, dm_ack_o}, 0);
    chk("rst_if_data", if_data_o, 0);
    chk("rst_dm_data", dm_data_o, 0);
    @(posedge clk); #1;
    if_req_i = 1'b0; dm_ce_i = CHIP_DISABLE; rst = RST_DISABLE;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      if_req_i = v.ifr; if_addr_i = v.ia; dm_ce_i = v.dce ? CHIP_ENABLE : CHIP_DISABLE;
      dm_we_i = v.dwe; dm_sel_i = v.dsel; dm_addr_i = v.da; dm_data_i = v.dd;
      if (v.pi) if_q.push_back(ram_model(v.ia));
      if (v.pd) begin
        dm_q.push_back(v.dwe ? last_rd : ram_model(v.da));
        if (!v.dwe) last_rd = ram_model(v.da);
      end
      @(negedge clk);
      chk($sformatf("v%0d_ctl", i),
          {23'(0), ram_ce_o == CHIP_ENABLE, ram_we_o, ram_sel_o, if_ack_o, dm_ack_o, stall_req_o},
          {23'(0), v.ce, v.we, v.sel, v.iack, v.dack, v.stall});
      chk($sformatf("v%0d_addr", i), ram_addr_o, v.addr);
      chk($sformatf("v%0d_wdata", i), ram_data_o, v.wd);
    end

    @(posedge clk); #1; if_req_i = 1'b1; if_addr_i = 32'h200; if_q.push_back(ram_model(32'h200));
    @(negedge clk); chk("ra_c0_ce", 32'(ram_ce_o == CHIP_ENABLE), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("ra_c1_addr", ram_addr_o, 32'h200);
    @(posedge clk); #1; rst = RST_ENABLE;
    @(negedge clk); chk("ra_c2_stall", 32'(stall_req_o), 0);
    @(posedge clk); #1; rst = RST_DISABLE;
    @(negedge clk);
    chk("ra_c3_ce", 32'(ram_ce_o == CHIP_ENABLE), 0);
    chk("ra_c3_ack", 32'(if_ack_o), 0);
    chk("ra_c3_stall", 32'(stall_req_o), 1);
    for (int c = 4; c <= 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("ra_c%0d_ce", c), 32'(ram_ce_o == CHIP_ENABLE), 32'(c != 6));
      chk($sformatf("ra_c%0d_ack", c), 32'(if_ack_o), 32'(c == 6));
    end
    @(posedge clk); #1; if_req_i = 1'b0;

    @(posedge clk); #1; rst = RST_ENABLE;
    @(posedge clk); #1; rst = RST_DISABLE;
    @(posedge clk); #1; if_req_i = 1'b1; if_addr_i = 32'h100; if_q.push_back(ram_model(32'h100));
    @(negedge clk); chk("w0_c0_ce", 32'(ram_ce_w0 == CHIP_ENABLE), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0_c1_ce", 32'(ram_ce_w0 == CHIP_ENABLE), 1);
    chk("w0_c1_addr", ram_addr_w0, 32'h100);
    chk("w0_c1_ack", 32'(if_ack_w0), 0);
    @(posedge clk); #1; if_req_i = 1'b0;
    @(negedge clk);
    chk("w0_c2_ack", 32'(if_ack_w0), 1);
    chk("w0_c2_data", if_data_w0, 32'h2402_0005);
    chk("w0_c2_ce", 32'(ram_ce_w0 == CHIP_ENABLE), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0_c3_ack", 32'(if_ack_w0), 0);
    chk("wd_c3_ack", 32'(if_ack_o), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("if_sb_left", if_q.size(), 0);
    chk("dm_sb_left", dm_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
